// File: rtl/sme_mask_dispenser.sv
// sme_mask_dispenser: snapshots the Keccak randomness core state and serves it
// as XLEN-bit mask words over a valid/ready handshake, driving the core's
// update strobe so consecutive snapshots are at least ROUNDS steps apart.
// Optional statistics counters are enabled by SME_MASK_DISPENSER_STATS_EN.
module sme_mask_dispenser #(
  parameter int LW     = 8,
  parameter int XLEN   = 32,
  parameter int WORDS  = (LW * 25) / XLEN,
  parameter int ROUNDS = 2,
  parameter int WARMUP = 4
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic [LW*25-1:0]  state,
  output logic              update,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              busy
`ifdef SME_MASK_DISPENSER_STATS_EN
  ,
  output logic [31:0]       stat_words,
  output logic [31:0]       stat_stall
`endif
);

  localparam int RMAX = (WARMUP > ROUNDS) ? WARMUP : ROUNDS;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int IW   = $clog2(WORDS + 1);

  localparam logic [IW-1:0] IDX_END   = IW'(WORDS);
  localparam logic [RW-1:0] RND_MAX   = RW'(RMAX);
  localparam logic [RW-1:0] RND_MIX   = RW'(ROUNDS);
  localparam logic [RW-1:0] WARM_LAST = RW'(WARMUP - 1);

  typedef enum logic [1:0] {WARM, FILL, SERVE} fsm_t;

  fsm_t                    r_fsm;
  fsm_t                    w_fsmNext;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           w_idxNext;
  logic [RW-1:0]           r_rnd;
  logic [RW-1:0]           w_rndNext;
  logic [WORDS*XLEN-1:0]   r_buf;
  logic [XLEN-1:0]         w_word;
  logic                    w_handshake;

  // State bits beyond the last whole word are never served.
  if (LW * 25 > WORDS * XLEN) begin : g_leftover
    logic w_unusedBits;
    assign w_unusedBits = ^state[LW*25-1:WORDS*XLEN];
  end

  assign rsp_valid   = (r_fsm == SERVE) && (r_idx < IDX_END);
  assign busy        = !rsp_valid;
  assign w_handshake = rsp_valid && rsp_ready;
  assign update      = g_resetn &&
                       ((r_fsm == WARM) || ((r_fsm == SERVE) && (r_rnd < RND_MIX)));
  assign rsp_data    = rsp_valid ? w_word : '0;

  // Select the buffered word pointed at by the read index.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (r_idx == IW'(k)) w_word = r_buf[k*XLEN +: XLEN];
    end
  end

  // Next-state decode; FILL is entered as soon as the index and round count
  // will reach their targets, so an always-ready consumer sees one bubble.
  always_comb begin
    w_rndNext = (update && (r_rnd != RND_MAX)) ? r_rnd + 1'b1 : r_rnd;
    w_idxNext = w_handshake ? r_idx + 1'b1 : r_idx;
    w_fsmNext = r_fsm;
    case (r_fsm)
      WARM:    if (update && (r_rnd == WARM_LAST)) w_fsmNext = FILL;
      FILL:    w_fsmNext = SERVE;
      SERVE:   if ((w_idxNext == IDX_END) && (w_rndNext >= RND_MIX)) w_fsmNext = FILL;
      default: w_fsmNext = WARM;
    endcase
    if (flush) w_fsmNext = (r_fsm == WARM) ? WARM : SERVE;
  end

  // Registered state: flush zeroises and empties, FILL captures the core state.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_fsm <= WARM;
      r_idx <= IDX_END;
      r_rnd <= '0;
      r_buf <= '0;
    end else begin
      r_fsm <= w_fsmNext;
      if (flush) begin
        r_idx <= IDX_END;
        r_rnd <= '0;
        r_buf <= '0;
      end else if (r_fsm == FILL) begin
        r_idx <= '0;
        r_rnd <= '0;
        r_buf <= state[WORDS*XLEN-1:0];
      end else begin
        r_idx <= w_idxNext;
        r_rnd <= w_rndNext;
      end
    end
  end

`ifdef SME_MASK_DISPENSER_STATS_EN
  // Saturating counters of delivered words and consumer stall cycles.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (w_handshake && (stat_words != 32'hFFFF_FFFF)) stat_words <= stat_words + 1'b1;
      if (rsp_ready && !rsp_valid && (stat_stall != 32'hFFFF_FFFF)) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: doc/sme_mask_dispenser.md
Name: sme_mask_dispenser

Overview:
- Downstream consumer of the SME Keccak randomness core.
- Snapshots the core's `LW*25`-bit state into a local buffer and serves it as `XLEN`-bit random mask words to SME functional units over a valid/ready handshake.
- Drives the core's `update` strobe so that every snapshot is separated from the previous one by at least `ROUNDS` permutation steps.
- No state bit is ever served twice.

Parameters:
- `LW`, 8, lane width of the attached Keccak core; state width is `LW*25`.
- `XLEN`, 32, width of one served mask word.
- `WORDS`, `(LW*25)/XLEN`, words per snapshot; must be >= 1; leftover state bits are unused.
- `ROUNDS`, 2, minimum `update` pulses between consecutive snapshots; >= 1.
- `WARMUP`, 4, `update` pulses issued after reset before the first snapshot; >= 1.

Ports:
- `g_clk`  in  1  clock.
- `g_resetn`  in  1  asynchronous active-low reset.
- `state`  in  `LW*25`  current Keccak state from the core.
- `update`  out  1  permutation step request to the core; one step per high cycle.
- `flush`  in  1  discard all buffered randomness (context switch or key change).
- `rsp_valid`  out  1  a mask word is available.
- `rsp_ready`  in  1  consumer accepts the word.
- `rsp_data`  out  `XLEN`  mask word.
- `busy`  out  1  high whenever `rsp_valid` is 0 because of warmup, refill or mixing.

Behaviour:
- Registers:
  - `fsm` in {WARM, FILL, SERVE}.
  - `idx`, 0..`WORDS`.
  - `rnd`, 0..max(`WARMUP`,`ROUNDS`), saturating.
  - `buf`, `WORDS*XLEN` bits.
- Reset (async, while `g_resetn`=0): `fsm`=WARM, `idx`=`WORDS`, `rnd`=0, `buf`=0. Outputs: `update`=0 (gated by `g_resetn`), `rsp_valid`=0, `rsp_data`=0, `busy`=1.
- `update` is decoded from registered state: high when `fsm`==WARM, or when `fsm`==SERVE and `rnd`<`ROUNDS`. Each high cycle increments `rnd`. The core's `state` reflects that step on the next edge.
- WARM: stays until `rnd`==`WARMUP`-1 with `update` high, then goes to FILL.
- FILL (exactly 1 cycle, `update`=0, `rsp_valid`=0):
  - word k of `buf` <= `state[k*XLEN +: XLEN]`.
  - `idx`<=0, `rnd`<=0, next state SERVE.
- SERVE:
  - `rsp_valid` = (`idx`<`WORDS`); `rsp_data` = word `idx` of `buf`.
  - When `rsp_valid` and `rsp_ready` are both high, `idx` increments.
  - Mixing (`update` pulses) runs in the background while words are served.
  - When `idx`==`WORDS` and `rnd`>=`ROUNDS`, go to FILL.
  - When `idx`==`WORDS` and `rnd`<`ROUNDS`, remain in SERVE with `rsp_valid`=0 until mixing completes.
- Steady state: a consumer that is always ready sees `WORDS` words back-to-back, then exactly 1 bubble cycle (FILL), provided `WORDS`>=`ROUNDS`.
- Once `rsp_valid` is asserted, `rsp_data` holds stable until it is accepted. `rsp_valid` never drops without acceptance except on `flush` or reset.
- `rsp_data` = 0 whenever `rsp_valid`=0 (no stale leakage).
- `flush`:
  - Next cycle: `idx`<=`WORDS`, `rnd`<=0; `buf` is zeroised.
  - In WARM, `flush` also restarts the warmup count.
  - If `flush` coincides with a handshake, that word counts as delivered; the remainder is discarded.
  - `flush` held high keeps `rsp_valid`=0 and `rnd` at 0; pulses issued during that time do not count toward the refill.
  - `flush` during FILL: the capture is discarded and the block returns to SERVE-empty with `rnd`=0.
- `busy` = !`rsp_valid`.

Optional Feature:
- Macro: `SME_MASK_DISPENSER_STATS_EN`.
- When defined:
  - Adds output `stat_words` (32 bits): count of completed handshakes, saturating at 0xFFFFFFFF, cleared by reset only.
  - Adds output `stat_stall` (32 bits): cycles with `rsp_ready`=1 and `rsp_valid`=0, saturating, cleared by reset only.
- When undefined: neither port nor their counters exist; behaviour is otherwise identical.

Test Plan:
- Reset release, `LW`=8, `XLEN`=32, `WARMUP`=4, `ROUNDS`=2: `update` is high for exactly 4 cycles, then 1 FILL cycle. `rsp_valid` rises on the 6th cycle after release, and `rsp_data` equals `state[31:0]` sampled in FILL.
- `rsp_ready` tied to 1: 6 words are accepted on consecutive cycles, then 1 bubble, then 6 new words. `update` is high for exactly 2 cycles after each FILL. No word repeats, checked against a Keccak model.
- `rsp_ready`=0 for 10 cycles mid-buffer: `rsp_valid` stays 1 and `rsp_data` is stable. `update` still totals exactly 2 pulses since the last FILL.
- `flush` after 3 accepted words: `rsp_valid`=0 and `rsp_data`=0 on the next cycle. Then 2 `update` cycles, 1 FILL, and the new word 0 differs from the discarded words 3-5.
- `ROUNDS`=8: after 6 words, `rsp_valid` stays low until the 8th `update` completes, then FILL, then valid.
- Async reset asserted mid-SERVE, off a clock edge: `rsp_valid`, `update` and `rsp_data` go to 0 immediately, and warmup restarts from 0 on release.
